// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receiver.
// Latency: none (types and a constant function only).
// Backpressure: not applicable.
package uart_pkg;

    typedef logic [7:0] uart_byte_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_t;

    // Width of the per-bit down counter; it holds values up to clks-1.
    function automatic int unsigned cnt_width(input int unsigned clks);
        return (clks < 2) ? 1 : $clog2(clks);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: received-byte valid/ready channel from the UART to its consumer.
// Latency: none (wires only).
// Backpressure: consumer holds rx_ready low to keep the head byte presented.
interface uart_rx_if;
    import uart_pkg::*;

    uart_byte_t rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous byte FIFO with a registered head output.
// Latency: a push appears at head_dat on the push edge; a pop exposes the next entry on the pop edge.
// Backpressure: a push into a full FIFO is ignored unless a pop happens in the same cycle.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  uart_byte_t push_dat,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output uart_byte_t head_dat
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    uart_byte_t  mem_q [DEPTH];
    uart_byte_t  mem_d [DEPTH];
    uart_byte_t  head_q, head_d;
    logic        push_ok;
    logic        pop_ok;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok   = pop && !empty;
    // Full is judged after a same-cycle pop, so push and pop both land.
    assign push_ok  = push && (!full || pop_ok);
    assign head_dat = head_q;

    // Next pointers/storage, and the head value as it will look after this edge.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_dat;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        head_d = (wr_ptr_d == rd_ptr_d) ? '0 : mem_d[rd_ptr_d[AW-1:0]];
    end

    // Pointer and head registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
        end
    end

    // Storage array; contents are don't-care while unoccupied.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver (8E1 when UART_RX_PARITY_EN is defined) with mid-bit sampling, byte FIFO, sticky errors.
// Latency: rx falling edge to FIFO push 3 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clocks (+CLKS_PER_BIT with parity).
// Backpressure: FIFO_DEPTH bytes buffered; a byte completing into a full FIFO is dropped and sets overrun.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 208,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      rx,
    uart_rx_if.master rx_if,
    input  logic      clear_errors,
`ifdef UART_RX_PARITY_EN
    output logic      parity_error,
`endif
    output logic      frame_error,
    output logic      overrun
);

    localparam int          CW        = cnt_width(CLKS_PER_BIT);
    // Counters are loaded with N-1 and sample when they reach zero, giving N-clock intervals.
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic          sync1_q, sync1_d;
    logic          rxs_q, rxs_d;
    uart_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    uart_byte_t    shift_q, shift_d;
    logic          frame_error_q, frame_error_d;
    logic          overrun_q, overrun_d;
    logic          push;
    logic          pop;
    logic          fe_set;
    logic          ov_set;
    logic          fifo_full;
    logic          fifo_empty;
    uart_byte_t    head_dat;
`ifdef UART_RX_PARITY_EN
    logic          parity_error_q, parity_error_d;
    logic          par_bad_q, par_bad_d;
    logic          pe_set;
`endif

    assign pop            = rx_if.rx_ready && !fifo_empty;
    assign rx_if.rx_valid = !fifo_empty;
    assign rx_if.rx_data  = head_dat;
    assign frame_error    = frame_error_q;
    assign overrun        = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_error   = parity_error_q;
`endif

    // Synchroniser shift and receive state machine next-state.
    always_comb begin
        sync1_d = rx;
        rxs_d   = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        push    = 1'b0;
        fe_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        pe_set    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    state_d = START;
                    cnt_d   = HALF_LOAD;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (rxs_q) begin
                        // Line went back high before mid-start: a glitch, not a frame.
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        cnt_d   = BIT_LOAD;
                        idx_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d[idx_q] = rxs_q;
                    cnt_d          = BIT_LOAD;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == '0) begin
                    // Even parity: data plus parity bit must hold an even number of ones.
                    par_bad_d = ^{shift_q, rxs_q};
                    pe_set    = ^{shift_q, rxs_q};
                    cnt_d     = BIT_LOAD;
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
`endif
            STOP: begin
                if (cnt_q == '0) begin
                    if (rxs_q) begin
                        // Return at mid-stop so a following start bit is caught on time.
`ifdef UART_RX_PARITY_EN
                        push = !par_bad_q;
`else
                        push = 1'b1;
`endif
                        state_d = IDLE;
                    end else begin
                        fe_set  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            BREAK: begin
                // Hold off until the line idles so a stuck-low line yields one error only.
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sticky error flags; a set event beats a same-cycle clear.
    always_comb begin
        ov_set        = push && fifo_full && !pop;
        frame_error_d = fe_set || (frame_error_q && !clear_errors);
        overrun_d     = ov_set || (overrun_q && !clear_errors);
`ifdef UART_RX_PARITY_EN
        parity_error_d = pe_set || (parity_error_q && !clear_errors);
`endif
    end

    // State, synchroniser and flag registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q       <= 1'b1;
            rxs_q         <= 1'b1;
            state_q       <= IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error_q <= 1'b0;
            par_bad_q      <= 1'b0;
`endif
        end else begin
            sync1_q       <= sync1_d;
            rxs_q         <= rxs_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
`ifdef UART_RX_PARITY_EN
            parity_error_q <= parity_error_d;
            par_bad_q      <= par_bad_d;
`endif
        end
    end

    uart_rx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .push_dat (shift_q),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head_dat (head_dat)
    );

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at CLKS_PER_BIT=8, FIFO_DEPTH=4.
// Latency: frames are driven bit-serially; bytes are checked as they are popped.
// Backpressure: rx_ready is toggled to exercise FIFO fill, overrun and simultaneous push/pop.
module tb_uart_rx;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int PUSH_EDGE = 2 + CPB / 2 + 10 * CPB;
`else
    localparam int PUSH_EDGE = 2 + CPB / 2 + 9 * CPB;
`endif

    logic clk = 1'b0;
    logic reset_n;
    logic rx;
    logic clear_errors;
    logic frame_error;
    logic overrun;
`ifdef UART_RX_PARITY_EN
    logic parity_error;
    logic bad_par = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    uart_rx_if u_if ();

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx           (rx),
        .rx_if        (u_if.master),
        .clear_errors (clear_errors),
`ifdef UART_RX_PARITY_EN
        .parity_error (parity_error),
`endif
        .frame_error  (frame_error),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every accepted byte is compared with the oldest expected one.
    always @(negedge clk) begin
        if (reset_n && u_if.rx_valid && u_if.rx_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_byte", 32'(u_if.rx_data), 32'h100);
            end else begin
                check("rx_data", 32'(u_if.rx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^b ^ bad_par);
`endif
        send_bit(stop_bit);
        rx = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] b, input logic expect_it);
        if (expect_it) exp_q.push_back(b);
        send_frame(b, 1'b1);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 4000) begin
            tick(1);
            t++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        tick(2);
    endtask

    task automatic pulse_clear();
        clear_errors = 1'b1;
        tick(1);
        clear_errors = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        rx           = 1'b1;
        clear_errors = 1'b0;
        u_if.rx_ready = 1'b1;
        tick(3);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_valid", 32'(u_if.rx_valid), 32'd0);
        check("rst_data", 32'(u_if.rx_data), 32'd0);
        check("rst_frame_error", 32'(frame_error), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        tick(4);

        // Back-to-back frames with the consumer always ready.
        send_good(8'h55, 1'b1);
        send_good(8'hA3, 1'b1);
        drain();
        @(negedge clk);
        check("b2b_frame_error", 32'(frame_error), 32'd0);
        check("b2b_overrun", 32'(overrun), 32'd0);
        check("b2b_empty_data", 32'(u_if.rx_data), 32'd0);
        tick(1);

        // Short low glitch is rejected at the mid-start check.
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(40);
        @(negedge clk);
        check("glitch_valid", 32'(u_if.rx_valid), 32'd0);
        check("glitch_frame_error", 32'(frame_error), 32'd0);
        tick(1);

        // Bad stop bit followed by a stuck-low line, then recovery.
        send_frame(8'h3C, 1'b0);
        rx = 1'b0;
        tick(40);
        @(negedge clk);
        check("fe_set", 32'(frame_error), 32'd1);
        check("fe_no_push", 32'(u_if.rx_valid), 32'd0);
        tick(1);
        rx = 1'b1;
        tick(16);
        send_good(8'h3C, 1'b1);
        drain();
        @(negedge clk);
        check("fe_sticky", 32'(frame_error), 32'd1);
        tick(1);
        pulse_clear();
        @(negedge clk);
        check("fe_cleared", 32'(frame_error), 32'd0);
        tick(1);

        // Five bytes into a four-deep FIFO with no reader: the fifth is lost.
        u_if.rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_good(8'(i), i <= DEPTH);
        tick(8);
        @(negedge clk);
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_valid", 32'(u_if.rx_valid), 32'd1);
        check("ovr_head", 32'(u_if.rx_data), 32'(exp_q[0]));
        tick(1);
        u_if.rx_ready = 1'b1;
        drain();
        @(negedge clk);
        check("ovr_drained_valid", 32'(u_if.rx_valid), 32'd0);
        check("ovr_drained_data", 32'(u_if.rx_data), 32'd0);
        tick(1);
        pulse_clear();
        @(negedge clk);
        check("ovr_cleared", 32'(overrun), 32'd0);
        tick(1);

        // Full FIFO, pop lands on the very edge the fifth byte is pushed.
        u_if.rx_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) send_good(8'h11 + 8'(i), 1'b1);
        exp_q.push_back(8'h15);
        fork
            send_frame(8'h15, 1'b1);
            begin
                tick(PUSH_EDGE);
                u_if.rx_ready = 1'b1;
                tick(1);
                u_if.rx_ready = 1'b0;
            end
        join
        @(negedge clk);
        check("simul_no_overrun", 32'(overrun), 32'd0);
        tick(1);
        u_if.rx_ready = 1'b1;
        drain();

`ifdef UART_RX_PARITY_EN
        // Wrong parity drops the byte even with a good stop bit.
        bad_par = 1'b1;
        send_frame(8'h07, 1'b1);
        bad_par = 1'b0;
        tick(8);
        @(negedge clk);
        check("pe_set", 32'(parity_error), 32'd1);
        check("pe_no_push", 32'(u_if.rx_valid), 32'd0);
        tick(1);
        send_good(8'h07, 1'b1);
        drain();
        pulse_clear();
        @(negedge clk);
        check("pe_cleared", 32'(parity_error), 32'd0);
        tick(1);
`endif

        // Reset in the middle of a data bit wipes FIFO, flags and the partial frame.
        u_if.rx_ready = 1'b0;
        send_frame(8'h3C, 1'b0);
        tick(16);
        send_good(8'h5A, 1'b0);
        tick(4);
        @(negedge clk);
        check("pre_rst_valid", 32'(u_if.rx_valid), 32'd1);
        check("pre_rst_fe", 32'(frame_error), 32'd1);
        tick(1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_valid", 32'(u_if.rx_valid), 32'd0);
        check("midrst_data", 32'(u_if.rx_data), 32'd0);
        check("midrst_fe", 32'(frame_error), 32'd0);
        check("midrst_ovr", 32'(overrun), 32'd0);
        tick(1);
        rx = 1'b1;
        reset_n = 1'b1;
        u_if.rx_ready = 1'b1;
        tick(16);
        send_good(8'h42, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
